// File: rtl/jackpot_pkg.sv
// rtl/jackpot_pkg.sv - LED codes, monitor states and decode helpers shared with the game FSM
package jackpot_pkg;

  localparam logic [3:0] LED_ZERO    = 4'b1010;
  localparam logic [3:0] LED_S1      = 4'b0001;
  localparam logic [3:0] LED_S2      = 4'b0010;
  localparam logic [3:0] LED_S3      = 4'b0100;
  localparam logic [3:0] LED_S4      = 4'b1000;
  localparam logic [3:0] LED_FLASH   = 4'b1111;
  localparam logic [3:0] LED_NOFLASH = 4'b0000;

  typedef enum logic [2:0] {
    ST_UNSYNC,
    ST_ZERO_SEEN,
    ST_SPIN,
    ST_FLASH_ON,
    ST_FLASH_OFF
  } mon_state_e;

  function automatic logic is_spin_code(input logic [3:0] code);
    return (code == LED_S1) || (code == LED_S2) || (code == LED_S3) || (code == LED_S4);
  endfunction

  // Non-spin codes map to 0 so pos reads 0 whenever it is not valid.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] code);
    case (code)
      LED_S2:  return 2'd1;
      LED_S3:  return 2'd2;
      LED_S4:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/jackpot_monitor_if.sv
// rtl/jackpot_monitor_if.sv - LED/switch observation bundle and monitor results
interface jackpot_monitor_if #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 4
);

  logic [3:0]       leds_in;
  logic [3:0]       sw_pulse;
  logic [1:0]       pos;
  logic             pos_valid;
  logic             win;
  logic             flashing;
  logic [CNT_W-1:0] lap_count;
  logic [CNT_W-1:0] miss_count;
  logic [WIN_W-1:0] win_count;
  logic             proto_err;

  modport master (
    output leds_in, sw_pulse,
    input  pos, pos_valid, win, flashing, lap_count, miss_count, win_count, proto_err
  );

  modport slave (
    input  leds_in, sw_pulse,
    output pos, pos_valid, win, flashing, lap_count, miss_count, win_count, proto_err
  );

endinterface

// File: rtl/jackpot_monitor_sat_counter.sv
// rtl/jackpot_monitor_sat_counter.sv - up counter that holds at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Count up on inc, stick at the maximum instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/jackpot_monitor.sv
// rtl/jackpot_monitor.sv - protocol checker and score decoder for the slot-machine LED stream
module jackpot_monitor
  import jackpot_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int WIN_W = 4
) (
  input  logic              divided_clk,
  input  logic              RESET,
  jackpot_monitor_if.slave  mon
);

  mon_state_e       state_q;
  logic [3:0]       prev_leds_q;
  logic [3:0]       prev_sw_q;
  logic             win_q;
  logic             flashing_q;
  logic             proto_err_q;

  logic [1:0]       lit_idx;
  logic             hit;
  logic             next_ok;
  logic             win_inc;
  logic             lap_inc;
  logic             miss_inc;
  logic [CNT_W-1:0] lap_count;
  logic [CNT_W-1:0] miss_count;
  logic [WIN_W-1:0] win_count;

  assign mon.pos_valid = is_spin_code(mon.leds_in);
  assign mon.pos       = onehot_to_idx(mon.leds_in);

  // Judge the step from the previously lit reel and the pulse seen alongside it.
  always_comb begin
    lit_idx  = onehot_to_idx(prev_leds_q);
    hit      = prev_sw_q[lit_idx];
    next_ok  = (mon.leds_in == idx_to_onehot(lit_idx + 2'd1));
    win_inc  = (state_q == ST_SPIN) && hit && (mon.leds_in == LED_FLASH);
    lap_inc  = (state_q == ST_SPIN) && !hit && next_ok && (lit_idx == 2'd3);
    miss_inc = (state_q == ST_SPIN) && ((prev_sw_q & ~idx_to_onehot(lit_idx)) != 4'b0000);
  end

  // Protocol tracker: history registers, state, and the registered flags.
  always_ff @(posedge divided_clk) begin
    if (RESET) begin
      state_q     <= ST_UNSYNC;
      prev_leds_q <= 4'b0000;
      prev_sw_q   <= 4'b0000;
      win_q       <= 1'b0;
      flashing_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      prev_leds_q <= mon.leds_in;
      prev_sw_q   <= mon.sw_pulse;
      win_q       <= 1'b0;
      flashing_q  <= 1'b0;
      case (state_q)
        ST_UNSYNC: begin
          if (mon.leds_in == LED_ZERO) begin
            state_q <= ST_ZERO_SEEN;
          end else if (is_spin_code(mon.leds_in)) begin
            state_q <= ST_SPIN;
          end
        end
        ST_ZERO_SEEN: begin
          if (mon.leds_in == LED_S1) begin
            state_q <= ST_SPIN;
          end else if (mon.leds_in != LED_ZERO) begin
            state_q     <= ST_UNSYNC;
            proto_err_q <= 1'b1;
          end
        end
        ST_SPIN: begin
          if (hit && (mon.leds_in == LED_FLASH)) begin
            state_q    <= ST_FLASH_ON;
            win_q      <= 1'b1;
            flashing_q <= 1'b1;
          end else if (!hit && next_ok) begin
            state_q <= ST_SPIN;
          end else begin
            state_q     <= ST_UNSYNC;
            proto_err_q <= 1'b1;
          end
        end
        ST_FLASH_ON: begin
          if (mon.leds_in == LED_NOFLASH) begin
            state_q    <= ST_FLASH_OFF;
            flashing_q <= 1'b1;
          end else begin
            state_q     <= ST_UNSYNC;
            proto_err_q <= 1'b1;
          end
        end
        ST_FLASH_OFF: begin
          if (mon.leds_in == LED_FLASH) begin
            state_q    <= ST_FLASH_ON;
            flashing_q <= 1'b1;
          end else begin
            state_q     <= ST_UNSYNC;
            proto_err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_UNSYNC;
        end
      endcase
    end
  end

  sat_counter #(.W(WIN_W)) u_win_cnt (
    .clk   (divided_clk),
    .rst   (RESET),
    .inc   (win_inc),
    .count (win_count)
  );

  sat_counter #(.W(CNT_W)) u_lap_cnt (
    .clk   (divided_clk),
    .rst   (RESET),
    .inc   (lap_inc),
    .count (lap_count)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (divided_clk),
    .rst   (RESET),
    .inc   (miss_inc),
    .count (miss_count)
  );

  assign mon.win        = win_q;
  assign mon.flashing   = flashing_q;
  assign mon.proto_err  = proto_err_q;
  assign mon.lap_count  = lap_count;
  assign mon.miss_count = miss_count;
  assign mon.win_count  = win_count;

endmodule

// File: tb/tb_jackpot_monitor.sv
// tb/tb_jackpot_monitor.sv - randomized and directed checks of jackpot_monitor against a protocol model
module tb_jackpot_monitor;

  localparam int CNT_W = 8;
  localparam int WIN_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int WMAX  = (1 << WIN_W) - 1;

  localparam int MU   = 0;
  localparam int MZ   = 1;
  localparam int MS   = 2;
  localparam int MON  = 3;
  localparam int MOFF = 4;

  logic divided_clk = 1'b0;
  logic RESET = 1'b1;

  always #5 divided_clk = ~divided_clk;

  jackpot_monitor_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) mon_if ();

  jackpot_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .divided_clk (divided_clk),
    .RESET       (RESET),
    .mon         (mon_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int         md;
  logic [3:0] m_pl;
  logic [3:0] m_ps;
  int         m_lap;
  int         m_miss;
  int         m_win;
  bit         m_err;
  bit         m_winp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int spin_idx(input logic [3:0] c);
    if ($countones(c) != 1) return -1;
    for (int i = 0; i < 4; i++) if (c[i]) return i;
    return -1;
  endfunction

  function automatic int sat_add(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_reset();
    md = MU; m_pl = 4'b0000; m_ps = 4'b0000;
    m_lap = 0; m_miss = 0; m_win = 0; m_err = 1'b0; m_winp = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] l, input logic [3:0] s);
    int k;
    int wrong;
    m_winp = 1'b0;
    case (md)
      MU: begin
        if (l == 4'b1010) md = MZ;
        else if (spin_idx(l) >= 0) md = MS;
      end
      MZ: begin
        if (l == 4'b0001) md = MS;
        else if (l != 4'b1010) begin m_err = 1'b1; md = MU; end
      end
      MS: begin
        k = spin_idx(m_pl);
        wrong = 0;
        for (int i = 0; i < 4; i++) if (i != k && m_ps[i]) wrong++;
        if (wrong > 0) m_miss = sat_add(m_miss, CMAX);
        if (m_ps[k] && l == 4'b1111) begin
          md = MON; m_winp = 1'b1; m_win = sat_add(m_win, WMAX);
        end else if (!m_ps[k] && spin_idx(l) == (k + 1) % 4) begin
          if (k == 3) m_lap = sat_add(m_lap, CMAX);
        end else begin
          m_err = 1'b1; md = MU;
        end
      end
      MON: begin
        if (l == 4'b0000) md = MOFF;
        else begin m_err = 1'b1; md = MU; end
      end
      default: begin
        if (l == 4'b1111) md = MON;
        else begin m_err = 1'b1; md = MU; end
      end
    endcase
    m_pl = l;
    m_ps = s;
  endtask

  task automatic check_regs();
    chk("win",        32'(mon_if.win),        32'(m_winp));
    chk("flashing",   32'(mon_if.flashing),   32'(md == MON || md == MOFF));
    chk("lap_count",  32'(mon_if.lap_count),  32'(m_lap));
    chk("miss_count", 32'(mon_if.miss_count), 32'(m_miss));
    chk("win_count",  32'(mon_if.win_count),  32'(m_win));
    chk("proto_err",  32'(mon_if.proto_err),  32'(m_err));
  endtask

  task automatic step(input logic [3:0] l, input logic [3:0] s);
    int idx;
    @(negedge divided_clk);
    mon_if.leds_in  = l;
    mon_if.sw_pulse = s;
    #1;
    idx = spin_idx(l);
    chk("pos_valid", 32'(mon_if.pos_valid), 32'(idx >= 0));
    chk("pos",       32'(mon_if.pos),       (idx >= 0) ? 32'(idx) : 32'd0);
    @(posedge divided_clk);
    model_step(l, s);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    @(negedge divided_clk);
    RESET = 1'b1;
    mon_if.leds_in  = 4'b0000;
    mon_if.sw_pulse = 4'b0000;
    @(posedge divided_clk);
    model_reset();
    #1;
    check_regs();
    chk("rst_pos", 32'(mon_if.pos), 32'd0);
    chk("rst_pos_valid", 32'(mon_if.pos_valid), 32'd0);
    @(negedge divided_clk);
    RESET = 1'b0;
  endtask

  initial begin
    logic [3:0] c;
    logic [3:0] s;
    int r;
    mon_if.leds_in  = 4'b0000;
    mon_if.sw_pulse = 4'b0000;
    model_reset();
    do_reset();

    // Clean spin with one lap
    step(4'b1010, 0); step(4'b0001, 0); step(4'b0010, 0); step(4'b0100, 0);
    step(4'b1000, 0); step(4'b0001, 0); step(4'b0010, 0);
    chk("t1_lap", 32'(mon_if.lap_count), 32'd1);
    chk("t1_miss", 32'(mon_if.miss_count), 32'd0);
    chk("t1_err", 32'(mon_if.proto_err), 32'd0);

    // Hit on S2 then flash sequence
    do_reset();
    step(4'b1010, 0); step(4'b0001, 0); step(4'b0010, 4'b0010);
    step(4'b1111, 0);
    chk("t2_win_pulse", 32'(mon_if.win), 32'd1);
    step(4'b0000, 0); step(4'b1111, 0);
    chk("t2_win_count", 32'(mon_if.win_count), 32'd1);
    chk("t2_flashing", 32'(mon_if.flashing), 32'd1);
    chk("t2_err", 32'(mon_if.proto_err), 32'd0);

    // Wrong-switch miss on S3
    do_reset();
    step(4'b1010, 0); step(4'b0001, 0); step(4'b0010, 0);
    step(4'b0100, 4'b0011); step(4'b1000, 0);
    chk("t3_miss", 32'(mon_if.miss_count), 32'd1);
    chk("t3_err", 32'(mon_if.proto_err), 32'd0);

    // Skip error, then resync and lap
    do_reset();
    step(4'b1010, 0); step(4'b0001, 0); step(4'b0100, 0);
    chk("t4_err_set", 32'(mon_if.proto_err), 32'd1);
    step(4'b1000, 0); step(4'b0001, 0);
    chk("t4_lap", 32'(mon_if.lap_count), 32'd1);
    chk("t4_err_sticky", 32'(mon_if.proto_err), 32'd1);

    // Hit on S4 but no flash follows
    do_reset();
    step(4'b1010, 0); step(4'b0001, 0); step(4'b0010, 0); step(4'b0100, 0);
    step(4'b1000, 4'b1000); step(4'b0001, 0);
    chk("t5_err", 32'(mon_if.proto_err), 32'd1);
    chk("t5_win_count", 32'(mon_if.win_count), 32'd0);

    // Lap counter saturation, then reset mid-flash
    do_reset();
    step(4'b1010, 0);
    for (int w = 0; w < 300; w++) begin
      step(4'b0001, 0); step(4'b0010, 0); step(4'b0100, 0); step(4'b1000, 0);
    end
    step(4'b0001, 0);
    chk("t6_lap_sat", 32'(mon_if.lap_count), 32'd255);
    step(4'b0010, 4'b0010); step(4'b1111, 0);
    chk("t6_flashing", 32'(mon_if.flashing), 32'd1);
    do_reset();
    chk("t6_rst_lap", 32'(mon_if.lap_count), 32'd0);
    chk("t6_rst_flash", 32'(mon_if.flashing), 32'd0);

    // Randomized, mostly-legal game traffic
    for (int n = 0; n < 800; n++) begin
      r = int'($urandom_range(99));
      case (md)
        MU:  c = (r < 40) ? 4'b1010 : (r < 80) ? 4'(4'b0001 << $urandom_range(3)) : 4'($urandom);
        MZ:  c = (r < 85) ? 4'b0001 : (r < 92) ? 4'b1010 : 4'($urandom);
        MS: begin
          if ((m_ps & m_pl) != 4'b0000) c = (r < 90) ? 4'b1111 : {m_pl[2:0], m_pl[3]};
          else c = (r < 92) ? {m_pl[2:0], m_pl[3]} : 4'($urandom);
        end
        MON: c = (r < 92) ? 4'b0000 : 4'($urandom);
        default: begin
          if (r < 15) begin
            do_reset();
            c = 4'b1010;
          end else begin
            c = (r < 90) ? 4'b1111 : 4'($urandom);
          end
        end
      endcase
      r = int'($urandom_range(99));
      if (spin_idx(c) >= 0) s = (r < 20) ? c : (r < 30) ? 4'($urandom) : 4'b0000;
      else s = (r < 10) ? 4'($urandom) : 4'b0000;
      step(c, s);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jackpot_monitor.md
Name: jackpot_monitor

Overview:
- Receive-side decoder for the slot-machine LED/switch interface. It observes the 4-bit LED state code driven by the game FSM and the per-switch edge pulses, and checks the stream against the game protocol.
- It decodes reel position, detects wins, counts laps and misses, and flags protocol violations.
- Sits beside the game FSM on the same divided clock. It feeds a score display and the self-check logic.

Parameters:
- CNT_W, 8, width of lap_count and miss_count (saturating).
- WIN_W, 4, width of win_count (saturating).

Ports:
- divided_clk  in  1  game clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high.
- leds_in  in  4  LED code from game FSM, registered at the source.
- sw_pulse  in  4  one-cycle switch rising-edge pulses, same clock domain.
- pos  out  2  decoded reel index 0..3; valid only when pos_valid=1.
- pos_valid  out  1  leds_in is a legal spin code (0001/0010/0100/1000).
- win  out  1  one-cycle pulse when a legal entry into flash is observed.
- flashing  out  1  monitor is in FLASH_ON or FLASH_OFF.
- lap_count  out  CNT_W  completed S4->S1 wraps.
- miss_count  out  CNT_W  cycles with a switch pulse not matching the lit LED.
- win_count  out  WIN_W  legal wins.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Interface is decided: reset RESET, synchronous, active-high; clock divided_clk.
- Codes:
  - ZERO=1010.
  - S1..S4=0001, 0010, 0100, 1000 (index 0..3).
  - FLASH=1111, NOFLASH=0000.
- Registers:
  - prev_leds, prev_sw: one-cycle history of leds_in and sw_pulse.
  - state ∈ {UNSYNC, ZERO_SEEN, SPIN, FLASH_ON, FLASH_OFF}.
- Reset values:
  - state=UNSYNC, prev_leds=0, prev_sw=0.
  - All outputs 0; counters 0; proto_err=0.
- pos and pos_valid are combinational from leds_in. pos=0 when invalid.
- UNSYNC (no checking, no counting):
  - leds_in=ZERO -> ZERO_SEEN.
  - Legal spin code -> SPIN.
  - Anything else -> stay.
- ZERO_SEEN:
  - Next code must be S1 -> SPIN.
  - ZERO repeated -> stay.
  - Otherwise set proto_err, go UNSYNC.
- SPIN, with prev_leds=Sk:
  - hit = prev_sw[k].
  - hit=1 and leds_in=FLASH -> FLASH_ON; win=1 for one cycle; win_count++.
  - hit=0 and leds_in=S((k+1) mod 4) -> stay in SPIN. If k=3, lap_count++.
  - hit=1 but leds_in≠FLASH -> proto_err, UNSYNC.
  - hit=0 but leds_in=FLASH -> proto_err, UNSYNC.
  - Any other code (skip, ZERO, NOFLASH, multi-hot) -> proto_err, UNSYNC.
- Miss rule: in SPIN only, if prev_sw has any bit other than bit k set, miss_count increments by 1 for that cycle, regardless of how many wrong bits. This is evaluated alongside the hit rule.
- FLASH_ON:
  - leds_in=NOFLASH -> FLASH_OFF.
  - FLASH repeated or anything else -> proto_err, UNSYNC.
- FLASH_OFF:
  - leds_in=FLASH -> FLASH_ON.
  - Anything else -> proto_err, UNSYNC.
  - A game reset shows ZERO here, which sets proto_err. The bench must pulse RESET together with the game reset.
- Switch pulses are ignored in FLASH states, ZERO_SEEN and UNSYNC.
- Counters saturate at all-ones and never wrap.
- proto_err stays set until RESET. The monitor keeps re-synchronising and counting after an error.
- Latency:
  - win, counter updates and state changes appear one cycle after the leds_in transition is sampled. This is the same edge that registers the new code into prev_leds.
- RESET mid-operation has priority over all updates and returns everything to its reset values on that edge.

Decomposition:
- Package jackpot_pkg:
  - LED code constants (ZERO, S1..S4, FLASH, NOFLASH).
  - Monitor state enum.
  - onehot_to_idx function.
  - The game FSM is also to import the codes from this package.
- Sub-module sat_counter:
  - Parameter W; ports clk, rst, inc, count.
  - Instantiated three times.

Test Plan:
- Reset then ZERO,S1,S2,S3,S4,S1,S2 with no pulses -> pos 0,1,2,3,0,1; lap_count=1; miss_count=0; proto_err=0.
- ZERO,S1,S2 with sw_pulse=0010 while leds_in=S2, then FLASH,NOFLASH,FLASH -> one win pulse; win_count=1; flashing=1; proto_err=0.
- In SPIN with leds_in=S3, sw_pulse=0011 for that one cycle, next S4 -> miss_count=1; proto_err=0.
- Sequence S1 then S3 (skip) -> proto_err=1 one cycle later. Then S4,S1 -> re-syncs; lap_count=1; proto_err stays 1.
- Hit pulse on S4 (sw_pulse=1000) but next code is S1 -> proto_err=1; win_count=0.
- 300 wraps with CNT_W=8 -> lap_count saturates at 255. Assert RESET mid-flash -> all outputs 0 next edge.
